// File: rtl/scope_defs.sv
// Shared scope display definitions: sample/column widths and capture FSM encodings.
// Used by the trace capture buffer and by the pixel discriminator downstream.
// Pure declarations; no logic.
package scope_defs;

  localparam int SAMPLE_W = 12;
  localparam int DEPTH    = 640;
  localparam int ADDR_W   = 10;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/trace_ram.sv
// Ping-pong sample memory: two banks of 2^ADDR_W samples, addressed as {bank, column}.
// Latency: write on the accepting edge, read data registered one edge after the address.
// Backpressure: none; a write and a read may occur every cycle.
module trace_ram #(
  parameter int SAMPLE_W = 12,
  parameter int ADDR_W   = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W:0]     waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic [ADDR_W:0]     raddr,
  output logic [SAMPLE_W-1:0] rdata
);

  // No reset on the array so it maps onto block RAM.
  logic [SAMPLE_W-1:0] mem [0:(2**(ADDR_W+1))-1];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; stale contents are masked by the caller.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_capture_buffer.sv
// Triggered capture of ADC samples into a ping-pong trace RAM; returns the sample for pixel_x.
// Latency: value follows pixel_x by one edge; samples are written on the edge that accepts them.
// Backpressure: none; sample_valid may be high every cycle, samples in DONE are dropped.
module trace_capture_buffer #(
  parameter int SAMPLE_W     = scope_defs::SAMPLE_W,
  parameter int DEPTH        = scope_defs::DEPTH,
  parameter int ADDR_W       = scope_defs::ADDR_W,
  parameter int TRIG_LEVEL   = 2048,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                frame_start,
  input  logic [ADDR_W-1:0]   pixel_x,
  output logic [SAMPLE_W-1:0] value,
  output logic                capturing,
  output logic                auto_trig
);

  import scope_defs::state_t;
  import scope_defs::ARMED;
  import scope_defs::CAPTURE;
  import scope_defs::DONE;

  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

  state_t              state;
  logic                bank_sel;
  logic                frame_ok;
  logic [SAMPLE_W-1:0] prev_sample;
  logic [ADDR_W-1:0]   wr_addr;
  logic [TO_W-1:0]     to_cnt;
  logic                rd_ok;
  logic [SAMPLE_W-1:0] rd_data;

  logic                level_trig;
  logic                timeout_trig;
  logic                trig;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_col;
  logic [ADDR_W:0]     wr_phys;
  logic [ADDR_W:0]     rd_phys;

  // Trigger detection and write-port steering; the trigger sample always lands at column 0.
  always_comb begin
    level_trig   = (prev_sample < SAMPLE_W'(TRIG_LEVEL)) && (sample_in >= SAMPLE_W'(TRIG_LEVEL));
    timeout_trig = (to_cnt == TO_W'(AUTO_TIMEOUT));
    trig         = sample_valid && (state == ARMED) && (level_trig || timeout_trig);
    wr_en        = trig || (sample_valid && (state == CAPTURE));
    wr_col       = (state == ARMED) ? {ADDR_W{1'b0}} : wr_addr;
    wr_phys      = {~bank_sel, wr_col};
    rd_phys      = {bank_sel, pixel_x};
  end

  // Capture FSM: arm, fill the back bank, then wait for a frame boundary to swap banks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ARMED;
      bank_sel    <= 1'b0;
      frame_ok    <= 1'b0;
      prev_sample <= '0;
      wr_addr     <= '0;
      to_cnt      <= '0;
      capturing   <= 1'b0;
      auto_trig   <= 1'b0;
    end else begin
      if (sample_valid) begin
        prev_sample <= sample_in;
      end
      case (state)
        ARMED: begin
          if (trig) begin
            state     <= CAPTURE;
            wr_addr   <= ADDR_W'(1);
            to_cnt    <= '0;
            capturing <= 1'b1;
            auto_trig <= ~level_trig;
          end else if (sample_valid) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (sample_valid) begin
            if (wr_addr == ADDR_W'(DEPTH - 1)) begin
              state     <= DONE;
              wr_addr   <= '0;
              capturing <= 1'b0;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end
        DONE: begin
          // Only a frame boundary seen here swaps, so a displayed trace never tears.
          if (frame_start) begin
            bank_sel <= ~bank_sel;
            frame_ok <= 1'b1;
            state    <= ARMED;
          end
        end
        default: begin
          state     <= ARMED;
          capturing <= 1'b0;
        end
      endcase
    end
  end

  // Read mask registered alongside the RAM read so it lines up with rd_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ok <= 1'b0;
    end else begin
      rd_ok <= frame_ok && (pixel_x < ADDR_W'(DEPTH));
    end
  end

  // Both operands are registers; the async-reset mask forces 0 immediately on reset.
  assign value = rd_ok ? rd_data : '0;

  trace_ram #(
    .SAMPLE_W(SAMPLE_W),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_phys),
    .wdata(sample_in),
    .raddr(rd_phys),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_trace_capture_buffer.sv
module tb_trace_capture_buffer;

  logic        clk;
  logic        reset;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic        frame_start;
  logic [9:0]  pixel_x;
  logic [11:0] value;
  logic        capturing;
  logic        auto_trig;
  logic [11:0] value_a;
  logic        capturing_a;
  logic        auto_trig_a;

  int checks;
  int failures;

  trace_capture_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .frame_start (frame_start),
    .pixel_x     (pixel_x),
    .value       (value),
    .capturing   (capturing),
    .auto_trig   (auto_trig)
  );

  trace_capture_buffer #(.AUTO_TIMEOUT(100)) dut_auto (
    .clk         (clk),
    .reset       (reset),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .frame_start (frame_start),
    .pixel_x     (pixel_x),
    .value       (value_a),
    .capturing   (capturing_a),
    .auto_trig   (auto_trig_a)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    step();
  endtask

  task automatic rd(input logic [9:0] x);
    sample_valid = 1'b0;
    pixel_x      = x;
    step();
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    frame_start  = 1'b0;
    reset        = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic swap();
    sample_valid = 1'b0;
    frame_start  = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    frame_start  = 1'b0;
    pixel_x      = 10'd5;
    #1;
    checks++;
    if (value !== 12'd0 || capturing !== 1'b0 || auto_trig !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs value=%0d cap=%0d auto=%0d want 0/0/0", value, capturing, auto_trig);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_pre_swap_reads();
    logic [9:0] xs [4];
    xs = '{10'd0, 10'd5, 10'd639, 10'd700};
    for (int i = 0; i < 4; i++) begin
      rd(xs[i]);
      checks++;
      if (value !== 12'd0) begin
        failures++;
        $display("FAIL pre_swap_px%0d value=%0d want=0", xs[i], value);
      end
    end
  endtask

  task automatic test_ramp();
    logic [9:0]  xs [4];
    logic [11:0] exp [4];
    do_reset();
    pixel_x = 10'd5;
    for (int i = 0; i < 768; i++) begin
      frame_start = (i == 400 || i == 767);
      push(12'(i * 16));
      frame_start = 1'b0;
      if (i == 127) begin
        checks++;
        if (capturing !== 1'b0) begin
          failures++;
          $display("FAIL ramp_pre_trig capturing=%0d want=0", capturing);
        end
      end
      if (i == 128) begin
        checks++;
        if (capturing !== 1'b1 || auto_trig !== 1'b0) begin
          failures++;
          $display("FAIL ramp_trig capturing=%0d auto=%0d want 1/0", capturing, auto_trig);
        end
      end
      if (i == 766 || i == 767) begin
        checks++;
        if (capturing !== (i == 766)) begin
          failures++;
          $display("FAIL ramp_end_i%0d capturing=%0d want=%0d", i, capturing, (i == 766));
        end
      end
    end
    rd(10'd5);
    checks++;
    if (value !== 12'd0) begin
      failures++;
      $display("FAIL ramp_no_swap value=%0d want=0", value);
    end
    swap();
    xs  = '{10'd0, 10'd5, 10'd639, 10'd700};
    exp = '{12'd2048, 12'd2128, 12'd4080, 12'd0};
    for (int i = 0; i < 4; i++) begin
      rd(xs[i]);
      checks++;
      if (value !== exp[i]) begin
        failures++;
        $display("FAIL ramp_px%0d value=%0d want=%0d", xs[i], value, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    pixel_x = 10'd5;
    push(12'd0);
    push(12'd3000);
    for (int k = 1; k < 640; k++) begin
      frame_start = (k == 300 || k == 639);
      push(12'(k * 3));
      frame_start = 1'b0;
      if (k == 300) begin
        checks++;
        if (value !== 12'd2128) begin
          failures++;
          $display("FAIL b2b_front_mid value=%0d want=2128", value);
        end
      end
      if (k == 639) begin
        checks++;
        if (capturing !== 1'b0 || value !== 12'd2128) begin
          failures++;
          $display("FAIL b2b_final_write cap=%0d value=%0d want 0/2128", capturing, value);
        end
      end
    end
    rd(10'd5);
    checks++;
    if (value !== 12'd2128) begin
      failures++;
      $display("FAIL b2b_no_swap value=%0d want=2128", value);
    end
    swap();
    rd(10'd5);
    checks++;
    if (value !== 12'd15) begin
      failures++;
      $display("FAIL b2b_swap1_px5 value=%0d want=15", value);
    end
    rd(10'd0);
    checks++;
    if (value !== 12'd3000) begin
      failures++;
      $display("FAIL b2b_swap1_px0 value=%0d want=3000", value);
    end
    rd(10'd639);
    checks++;
    if (value !== 12'd1917) begin
      failures++;
      $display("FAIL b2b_swap1_px639 value=%0d want=1917", value);
    end
    // Third trace goes back into the bank that held the ramp.
    pixel_x = 10'd5;
    push(12'd2500);
    for (int k = 1; k < 640; k++) begin
      push(12'd4000);
      if (k == 320) begin
        checks++;
        if (value !== 12'd15) begin
          failures++;
          $display("FAIL b2b_front_third value=%0d want=15", value);
        end
      end
    end
    swap();
    rd(10'd5);
    checks++;
    if (value !== 12'd4000) begin
      failures++;
      $display("FAIL b2b_swap2_px5 value=%0d want=4000", value);
    end
    rd(10'd0);
    checks++;
    if (value !== 12'd2500) begin
      failures++;
      $display("FAIL b2b_swap2_px0 value=%0d want=2500", value);
    end
    rd(10'd700);
    checks++;
    if (value !== 12'd0) begin
      failures++;
      $display("FAIL b2b_px700 value=%0d want=0", value);
    end
  endtask

  task automatic test_reset_mid_capture();
    logic [9:0]  xs [4];
    logic [11:0] exp [4];
    pixel_x = 10'd5;
    push(12'd0);
    push(12'd3500);
    for (int k = 1; k < 300; k++) begin
      push(12'(100 + k));
    end
    sample_valid = 1'b0;
    #3;
    checks++;
    if (value !== 12'd4000 || capturing !== 1'b1) begin
      failures++;
      $display("FAIL midrst_before value=%0d cap=%0d want 4000/1", value, capturing);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (value !== 12'd0 || capturing !== 1'b0 || auto_trig !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async value=%0d cap=%0d auto=%0d want 0/0/0", value, capturing, auto_trig);
    end
    step();
    reset = 1'b0;
    rd(10'd5);
    checks++;
    if (value !== 12'd0) begin
      failures++;
      $display("FAIL midrst_after value=%0d want=0", value);
    end
    push(12'd3800);
    for (int k = 1; k < 640; k++) begin
      push(12'(100 + k));
    end
    swap();
    xs  = '{10'd0, 10'd5, 10'd300, 10'd639};
    exp = '{12'd3800, 12'd105, 12'd400, 12'd739};
    for (int i = 0; i < 4; i++) begin
      rd(xs[i]);
      checks++;
      if (value !== exp[i]) begin
        failures++;
        $display("FAIL midrst_px%0d value=%0d want=%0d", xs[i], value, exp[i]);
      end
    end
  endtask

  task automatic test_auto();
    logic [9:0]  xs [4];
    logic [11:0] exp [4];
    do_reset();
    for (int n = 1; n <= 740; n++) begin
      push(12'd1000);
      if (n == 100) begin
        checks++;
        if (capturing_a !== 1'b0) begin
          failures++;
          $display("FAIL auto_n100 capturing=%0d want=0", capturing_a);
        end
      end
      if (n == 101) begin
        checks++;
        if (capturing_a !== 1'b1 || auto_trig_a !== 1'b1 || capturing !== 1'b0) begin
          failures++;
          $display("FAIL auto_n101 cap=%0d auto=%0d main_cap=%0d want 1/1/0", capturing_a, auto_trig_a, capturing);
        end
      end
    end
    checks++;
    if (capturing_a !== 1'b0 || auto_trig_a !== 1'b1) begin
      failures++;
      $display("FAIL auto_done cap=%0d auto=%0d want 0/1", capturing_a, auto_trig_a);
    end
    swap();
    xs  = '{10'd0, 10'd320, 10'd639, 10'd700};
    exp = '{12'd1000, 12'd1000, 12'd1000, 12'd0};
    for (int i = 0; i < 4; i++) begin
      rd(xs[i]);
      checks++;
      if (value_a !== exp[i]) begin
        failures++;
        $display("FAIL auto_px%0d value=%0d want=%0d", xs[i], value_a, exp[i]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_pre_swap_reads();
    test_ramp();
    test_back_to_back();
    test_reset_mid_capture();
    test_auto();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_capture_buffer.md
# trace_capture_buffer

Upstream feeder for the pixel discriminator in the scope display path. Captures a triggered window of 12-bit ADC samples into a double-buffered (ping-pong) sample memory and, during display, returns the sample for the current column `pixel_x`. The discriminator compares that value against `pixel_y`. Bank swaps occur only at frame start, so a displayed trace never tears.

## Interface
- `SAMPLE_W`, 12: ADC sample width.
- `DEPTH`, 640: samples per trace, one per visible column.
- `ADDR_W`, 10: column/address width; requires 2^ADDR_W ≥ DEPTH.
- `TRIG_LEVEL`, 2048: rising-edge trigger threshold, unsigned.
- `AUTO_TIMEOUT`, 65535: samples spent in ARMED before a forced (auto) trigger.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `sample_in`  in  SAMPLE_W: ADC sample.
- `sample_valid`  in  1: `sample_in` is valid this cycle, one sample per pulse.
- `frame_start`  in  1: single-cycle pulse at the start of vertical blanking.
- `pixel_x`  in  ADDR_W: current display column.
- `value`  out  SAMPLE_W: sample for `pixel_x`, registered.
- `capturing`  out  1: high while in CAPTURE.
- `auto_trig`  out  1: the last trace was captured by timeout, not by a level crossing.

## Operation
- States:
  - ARMED: wait for a trigger.
  - CAPTURE: write samples.
  - DONE: capture complete, wait for the swap.
- Reset values:
  - State is ARMED.
  - `bank_sel`=0, `frame_ok`=0.
  - `prev_sample`=0, write address=0, timeout counter=0.
  - `value`=0, `capturing`=0, `auto_trig`=0.
- Trigger condition, checked only on `sample_valid` in ARMED: `prev_sample` < TRIG_LEVEL and `sample_in` ≥ TRIG_LEVEL.
  - The triggering sample is written to address 0.
  - State moves to CAPTURE with write address 1.
  - `auto_trig` is set to 0.
- `prev_sample` updates on every `sample_valid`, in every state.
- Timeout in ARMED:
  - The counter increments on each `sample_valid` that does not trigger.
  - When the counter reaches AUTO_TIMEOUT, the current sample is treated as a trigger and `auto_trig` is set to 1.
  - The counter clears when leaving ARMED.
- CAPTURE:
  - Each `sample_valid` writes to the back bank (`~bank_sel`) at the write address, then increments the address.
  - After the write to address DEPTH-1, state moves to DONE.
- DONE:
  - `sample_valid` is ignored.
  - On `frame_start`: `bank_sel` toggles, `frame_ok` is set to 1, and state moves to ARMED.
- `frame_start` in ARMED or CAPTURE has no effect; the swap waits for the first `frame_start` seen in DONE.
- Read path:
  - `value` ← front bank (`bank_sel`) at `pixel_x` when `frame_ok`=1 and `pixel_x` < DEPTH.
  - Otherwise `value` ← 0.
- Memory contents are not reset. `frame_ok` masks stale data until the first swap.
- Address arithmetic: the physical address is {bank, column}. Write addresses never exceed DEPTH-1.

## Timing
- Read latency is 1 cycle: `pixel_x` at edge N gives `value` valid after edge N+1.
- Write happens on the same edge as the sample is accepted (`sample_valid` high).
- `capturing` is registered. It rises on the edge that accepts the trigger sample and falls on the edge that writes address DEPTH-1.
- Swap: `bank_sel` toggles on the `frame_start` edge. Reads from the cycle after that edge use the new bank.
- A `frame_start` in the same cycle as the final CAPTURE write is ignored; the swap happens on the next `frame_start`.
- Reset asserted mid-capture: the partial trace is discarded, state returns to ARMED, and `value` is 0 until a full capture and swap complete.
- Throughput: `sample_valid` may be high every cycle.

## Structure
- Shared package or include `scope_defs`:
  - SAMPLE_W, DEPTH, ADDR_W.
  - State encodings: ARMED=2'd0, CAPTURE=2'd1, DONE=2'd2.
  - The discriminator uses the same SAMPLE_W/ADDR_W.
- Sub-module `trace_ram`: simple dual-port RAM, 2·2^ADDR_W × SAMPLE_W.
  - One synchronous write port and one registered read port.
  - Inferred as block RAM with no reset on the array.
- FSM, counters, trigger compare and `value` masking live in the top module.

## Test plan
- Ramp 0→4095 in steps of 16 with `sample_valid` every cycle:
  - Trigger on the first sample ≥2048 (sample 2048), so address 0 holds 2048.
  - After `frame_start`, `pixel_x`=5 gives `value`=2128 one cycle later.
- Constant 1000 input with AUTO_TIMEOUT=100:
  - Auto-trigger on the 101st sample; `auto_trig`=1.
  - After the swap, every column reads 1000.
- Reads before the first swap:
  - `value`=0 for all `pixel_x`.
  - `pixel_x`=700 reads 0 after a valid swap as well.
- `frame_start` pulsed mid-capture and on the final-write cycle:
  - No swap occurs; the old trace remains visible.
  - The swap occurs on the next `frame_start`.
- Reset asserted at write address 300:
  - All outputs are 0 immediately (async).
  - A fresh trigger restarts writing at address 0.
- Two consecutive captures with different signals:
  - The front bank is unchanged during the second capture.
  - It alternates correctly after each swap.
